filtro_quadro: RTL and testbench
================================

# filtro_quadro

Streaming frame controller for the 3x3 impulse-median filter datapath. It accepts a raster-order 8-bit pixel stream and builds the 3x3 neighbourhood with internal line delays. It drives one `filtro` instance and returns the filtered stream with ready/valid flow control. Border pixels bypass the filter. It sits between the pixel source (camera/DMA reader) and the frame writer.

## Interface
- `LARGURA`, default 640: pixels per line; must be ≥ 4.
- `ALTURA`, default 480: lines per frame; must be ≥ 3.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ent_valido` input 1: input pixel valid.
- `ent_pronto` output 1: block accepts the input pixel this cycle.
- `ent_pixel` input 8: input pixel, raster order, row 0 first.
- `sai_valido` output 1: output pixel valid.
- `sai_pronto` input 1: downstream accepts the output pixel.
- `sai_pixel` output 8: filtered pixel.
- `sai_fim` output 1: qualifies the last output pixel of the frame, together with `sai_valido`.
- `ocupado` output 1: high in every state except OCIOSO.
- `corrigidos` output 16: only present with the macro; see Configuration.

## Operation
- **Delay chain**
  - Shift chain of 2·LARGURA+3 bytes.
  - It advances one position per `avanco` pulse, where `avanco` = `ent_valido`&&`ent_pronto` in ENCHENDO/PROCESSANDO, or one flush step in ESVAZIANDO.
  - Window taps E0..E8 = chain positions {2L+2, 2L+1, 2L, L+2, L+1, L, 2, 1, 0}, with position 0 the newest pixel and L = LARGURA. E4 is the centre.
- **State machine**
  - OCIOSO: first accepted pixel goes to ENCHENDO.
  - ENCHENDO: after LARGURA+1 accepted pixels, the next acceptance goes to PROCESSANDO. No output in this state.
  - PROCESSANDO: each acceptance produces one output. After the ALTURA·LARGURA-th acceptance, go to ESVAZIANDO.
  - ESVAZIANDO: produces LARGURA+1 outputs, shifting 0x00 into the chain. Then return to OCIOSO.
- **Output position**
  - Counters `col` (0..LARGURA-1) and `lin` (0..ALTURA-1) track the output pixel position.
  - Both wrap at end of line and end of frame, and clear in OCIOSO.
- **Output selection**
  - If `lin`∈{0, ALTURA-1} or `col`∈{0, LARGURA-1}, `sai_pixel` = E4 (passthrough).
  - Otherwise `sai_pixel` = `filtro` S0, which is the median only when E4 is 0x00 or 0xFF.
  - Every ESVAZIANDO output is a border pixel, so the zero padding never reaches the median path.
- **Flow control**
  - `ent_pronto` = state∈{OCIOSO, ENCHENDO, PROCESSANDO} && (!`sai_valido` || `sai_pronto`).
  - In ESVAZIANDO, `ent_pronto`=0. A flush step occurs when !`sai_valido` || `sai_pronto`.
  - Output register: loads when `avanco` fires in a producing step. Holds while `sai_valido`&&!`sai_pronto`. Clears `sai_valido` on handshake with no new load.
- **Frame boundary**: pixels offered after the last input of a frame wait, with `ent_pronto`=0, until the flush completes.
- **Reset mid-frame**: all state clears to OCIOSO. The partial frame is discarded and no output is produced for it.

## Timing
- Reset values: `ent_pronto`=1, `sai_valido`=0, `sai_pixel`=0x00, `sai_fim`=0, `ocupado`=0, `corrigidos`=0, chain=0, counters=0.
- Latency: output pixel k is registered on the edge that accepts input k+LARGURA+1, so `sai_valido` is visible the next cycle.
- The final LARGURA+1 outputs come from flush steps.
- Throughput: one pixel per cycle with `ent_valido` and `sai_pronto` held high.
- `sai_fim` coincides with the last flush output. `ocupado` drops the cycle after that output's handshake.
- Simultaneous output handshake and new load in the same cycle: no bubble.

## Configuration
- `FILTRO_CONTADOR_EN` defined:
  - `corrigidos` port exists.
  - It counts output pixels where the median path was selected and E4∈{0x00, 0xFF}.
  - It saturates at 0xFFFF, clears on reset and on the OCIOSO→ENCHENDO transition, and holds its value after the frame.
- `FILTRO_CONTADOR_EN` undefined: no port and no counter logic.

## Structure
- Package `filtro_pkg`:
  - state enum `estado_t` {OCIOSO, ENCHENDO, PROCESSANDO, ESVAZIANDO};
  - `PIXEL_W`=8;
  - constants for the impulse codes 0x00 and 0xFF.
- Sub-module `linha_atraso` (parameter PROF): enable-gated byte delay line. It is instantiated twice with PROF=LARGURA-3, between the 3-tap row groups.
- `filtro` is instantiated once, combinational.

## Test plan
- LARGURA=4, ALTURA=4, pixels 0x10..0x1F, `sai_pronto`=1 → 16 outputs identical to the inputs, first `sai_valido` 6 cycles after the first acceptance, `sai_fim` on the 16th output.
- Same frame with pixel (1,1)=0xFF and all other pixels 0x40 → output (1,1)=0x40. With the macro defined, `corrigidos`=1.
- Pixel (0,0)=0x00 (border) → passes through as 0x00; `corrigidos` unchanged.
- `sai_pronto` toggled 1/0 every cycle → same 16 values in order; `ent_pronto` low whenever the output is held.
- `rst` pulsed after 7 accepted pixels → all outputs at reset values. The following full frame processes correctly from pixel 0.
- Back-to-back frames with `ent_valido` held high → `ent_pronto` low during the 5 flush steps, then the second frame is accepted and produces 16 outputs.

Source files
------------

// File: rtl/filtro_pkg.sv
// Shared types and constants for the 3x3 impulse-median frame filter.
//   estado_t    : frame controller states
//   PIXEL_W     : pixel width in bits
//   janela_t    : 3x3 window, index 0 = oldest tap (E0), index 8 = newest (E8)
//   eh_impulso  : true for the impulse codes 0x00 / 0xFF
package filtro_pkg;

    localparam int unsigned PIXEL_W = 8;

    localparam logic [PIXEL_W-1:0] IMPULSO_PRETO  = 8'h00;
    localparam logic [PIXEL_W-1:0] IMPULSO_BRANCO = 8'hFF;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        ENCHENDO    = 2'd1,
        PROCESSANDO = 2'd2,
        ESVAZIANDO  = 2'd3
    } estado_t;

    typedef logic [8:0][PIXEL_W-1:0] janela_t;

    function automatic logic eh_impulso(input logic [PIXEL_W-1:0] p);
        return (p == IMPULSO_PRETO) || (p == IMPULSO_BRANCO);
    endfunction

endpackage

// File: rtl/filtro.sv
// Combinational impulse-median filter on a 3x3 window.
//   e  : window E0..E8, E4 is the centre
//   s0 : median of the nine taps when E4 is an impulse (0x00/0xFF), else E4
module filtro
    import filtro_pkg::*;
(
    input  janela_t            e,
    output logic [PIXEL_W-1:0] s0
);

    logic [PIXEL_W-1:0] mediana;
    logic [3:0]         menores;

    // Rank selection: ties broken by index so exactly one tap has rank 4.
    always_comb begin
        mediana = '0;
        menores = '0;
        for (int i = 0; i < 9; i++) begin
            menores = '0;
            for (int j = 0; j < 9; j++) begin
                if ((j != i) &&
                    ((e[4'(j)] < e[4'(i)]) || ((e[4'(j)] == e[4'(i)]) && (j < i))))
                    menores = menores + 4'd1;
            end
            if (menores == 4'd4)
                mediana = e[4'(i)];
        end
        s0 = eh_impulso(e[4]) ? mediana : e[4];
    end

endmodule

// File: rtl/linha_atraso.sv
// Enable-gated byte delay line of PROF stages.
//   clk, rst : clock, async active-high reset (contents clear to 0)
//   en       : shift one position
//   ent      : byte entering the line
//   sai      : byte that entered PROF shifts ago
module linha_atraso
    import filtro_pkg::*;
#(
    parameter int unsigned PROF = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PIXEL_W-1:0] ent,
    output logic [PIXEL_W-1:0] sai
);

    logic [PROF-1:0][PIXEL_W-1:0] mem;

    generate
        if (PROF == 1) begin : g_um
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     mem <= '0;
                else if (en) mem[0] <= ent;
            end
        end else begin : g_varios
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     mem <= '0;
                else if (en) mem <= {mem[PROF-2:0], ent};
            end
        end
    endgenerate

    assign sai = mem[PROF-1];

endmodule

// File: rtl/filtro_quadro.sv
// Streaming frame controller for the 3x3 impulse-median filter.
// Builds the neighbourhood from a raster pixel stream with two line delays,
// passes border pixels through and filters the interior.
//   clk, rst              : clock, async active-high reset
//   ent_valido/ent_pronto : input handshake, ent_pixel raster order
//   sai_valido/sai_pronto : output handshake, sai_pixel filtered pixel
//   sai_fim               : last pixel of the frame (with sai_valido)
//   ocupado               : high whenever the controller is not idle
//   corrigidos            : count of impulses replaced by the median
//                           (only when FILTRO_CONTADOR_EN is defined)
module filtro_quadro
    import filtro_pkg::*;
#(
    parameter int unsigned LARGURA = 640,
    parameter int unsigned ALTURA  = 480
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ent_valido,
    output logic               ent_pronto,
    input  logic [PIXEL_W-1:0] ent_pixel,
    output logic               sai_valido,
    input  logic               sai_pronto,
    output logic [PIXEL_W-1:0] sai_pixel,
    output logic               sai_fim,
    output logic               ocupado
`ifdef FILTRO_CONTADOR_EN
    ,
    output logic [15:0]        corrigidos
`endif
);

    localparam int unsigned TOTAL = LARGURA * ALTURA;
    localparam int unsigned CW    = $clog2(TOTAL + 1);
    localparam int unsigned COLW  = $clog2(LARGURA);
    localparam int unsigned LINW  = $clog2(ALTURA);

    estado_t            estado, estado_prox;
    logic [CW-1:0]      cont, cont_prox;
    logic [COLW-1:0]    col;
    logic [LINW-1:0]    lin;
    logic               livre_c, avanco_c, produz_c, borda_c, fim_c;
    logic [PIXEL_W-1:0] novo_c, filtrado_c, saida_c;
    janela_t            janela_c;

    // Chain registers named by position (L = LARGURA); d1/d2 are positions L-1 and 2L-1.
    logic [PIXEL_W-1:0] p0, p1, p2, pl, pl1, pl2, p2l, p2l1;
    logic [PIXEL_W-1:0] d1, d2;

    assign livre_c    = !sai_valido || sai_pronto;
    assign ent_pronto = (estado != ESVAZIANDO) && livre_c;
    assign novo_c     = (estado == ESVAZIANDO) ? IMPULSO_PRETO : ent_pixel;

    // Next state, chain advance and "this advance produces an output".
    always_comb begin
        estado_prox = estado;
        cont_prox   = cont;
        avanco_c    = 1'b0;
        produz_c    = 1'b0;
        case (estado)
            OCIOSO: begin
                avanco_c = ent_valido && ent_pronto;
                if (avanco_c) begin
                    estado_prox = ENCHENDO;
                    cont_prox   = CW'(1);
                end
            end
            ENCHENDO: begin
                avanco_c = ent_valido && ent_pronto;
                if (avanco_c) begin
                    cont_prox = cont + CW'(1);
                    if (cont == CW'(LARGURA + 1)) begin
                        produz_c    = 1'b1;
                        estado_prox = PROCESSANDO;
                    end
                end
            end
            PROCESSANDO: begin
                avanco_c = ent_valido && ent_pronto;
                if (avanco_c) begin
                    produz_c = 1'b1;
                    if (cont == CW'(TOTAL - 1)) begin
                        estado_prox = ESVAZIANDO;
                        cont_prox   = '0;
                    end else begin
                        cont_prox = cont + CW'(1);
                    end
                end
            end
            ESVAZIANDO: begin
                // After the last flush step, stay until its output is taken.
                if (cont != CW'(LARGURA + 1)) begin
                    avanco_c = livre_c;
                    produz_c = livre_c;
                    if (livre_c)
                        cont_prox = cont + CW'(1);
                end else if (livre_c) begin
                    estado_prox = OCIOSO;
                    cont_prox   = '0;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado  <= OCIOSO;
            cont    <= '0;
            ocupado <= 1'b0;
        end else begin
            estado  <= estado_prox;
            cont    <= cont_prox;
            ocupado <= (estado_prox != OCIOSO);
        end
    end

    // Chain head/taps. Position 2L+2 is never stored: the window is taken
    // after the shift, so E0 comes straight from position 2L+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0   <= '0;
            p1   <= '0;
            p2   <= '0;
            pl   <= '0;
            pl1  <= '0;
            pl2  <= '0;
            p2l  <= '0;
            p2l1 <= '0;
        end else if (avanco_c) begin
            p0   <= novo_c;
            p1   <= p0;
            p2   <= p1;
            pl   <= d1;
            pl1  <= pl;
            pl2  <= pl1;
            p2l  <= d2;
            p2l1 <= p2l;
        end
    end

    linha_atraso #(.PROF(LARGURA - 3)) u_atraso1 (
        .clk (clk),
        .rst (rst),
        .en  (avanco_c),
        .ent (p2),
        .sai (d1)
    );

    linha_atraso #(.PROF(LARGURA - 3)) u_atraso2 (
        .clk (clk),
        .rst (rst),
        .en  (avanco_c),
        .ent (pl2),
        .sai (d2)
    );

    // Window as it will stand after the current advance.
    assign janela_c[0] = p2l1;
    assign janela_c[1] = p2l;
    assign janela_c[2] = d2;
    assign janela_c[3] = pl1;
    assign janela_c[4] = pl;
    assign janela_c[5] = d1;
    assign janela_c[6] = p1;
    assign janela_c[7] = p0;
    assign janela_c[8] = novo_c;

    filtro u_filtro (
        .e  (janela_c),
        .s0 (filtrado_c)
    );

    assign borda_c = (lin == '0) || (lin == LINW'(ALTURA - 1)) ||
                     (col == '0) || (col == COLW'(LARGURA - 1));
    assign fim_c   = (lin == LINW'(ALTURA - 1)) && (col == COLW'(LARGURA - 1));
    assign saida_c = borda_c ? janela_c[4] : filtrado_c;

    // Output position of the pixel being loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            lin <= '0;
        end else if (estado == OCIOSO) begin
            col <= '0;
            lin <= '0;
        end else if (produz_c) begin
            if (col == COLW'(LARGURA - 1)) begin
                col <= '0;
                lin <= (lin == LINW'(ALTURA - 1)) ? '0 : lin + LINW'(1);
            end else begin
                col <= col + COLW'(1);
            end
        end
    end

    // Output register: a load wins over the handshake clear (no bubble).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sai_valido <= 1'b0;
            sai_pixel  <= '0;
            sai_fim    <= 1'b0;
        end else if (produz_c) begin
            sai_valido <= 1'b1;
            sai_pixel  <= saida_c;
            sai_fim    <= fim_c;
        end else if (sai_pronto) begin
            sai_valido <= 1'b0;
            sai_fim    <= 1'b0;
        end
    end

`ifdef FILTRO_CONTADOR_EN
    // Saturating count of impulses sent through the median path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corrigidos <= '0;
        end else if ((estado == OCIOSO) && avanco_c) begin
            corrigidos <= '0;
        end else if (produz_c && !borda_c && eh_impulso(janela_c[4]) &&
                     (corrigidos != 16'hFFFF)) begin
            corrigidos <= corrigidos + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_filtro_quadro.sv
module tb_filtro_quadro;

    localparam int L = 4;
    localparam int H = 4;
    localparam int N = L * H;

    logic       clk = 1'b0;
    logic       rst;
    logic       ent_valido;
    logic       ent_pronto;
    logic [7:0] ent_pixel;
    logic       sai_valido;
    logic       sai_pronto = 1'b1;
    logic [7:0] sai_pixel;
    logic       sai_fim;
    logic       ocupado;
`ifdef FILTRO_CONTADOR_EN
    logic [15:0] corrigidos;
`endif

    filtro_quadro #(.LARGURA(L), .ALTURA(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .ent_valido (ent_valido),
        .ent_pronto (ent_pronto),
        .ent_pixel  (ent_pixel),
        .sai_valido (sai_valido),
        .sai_pronto (sai_pronto),
        .sai_pixel  (sai_pixel),
        .sai_fim    (sai_fim),
        .ocupado    (ocupado)
`ifdef FILTRO_CONTADOR_EN
        ,
        .corrigidos (corrigidos)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] pix;
        logic       fim;
    } saida_t;

    saida_t     fila[$];
    int         checks = 0;
    int         falhas = 0;
    int         ciclo = 0;
    logic [7:0] quadro [N];
    int         modo_pronto = 0;
    bit         ignorar = 0;
    int         corr_esp = 0;
    int         t_acc = -1;
    int         t_val = -1;
    int         fins_vistos = 0;
    bit         fim_pend = 0;

    always @(posedge clk) ciclo <= ciclo + 1;

    task automatic checar(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            falhas++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, obtido, esperado, $time);
        end
    endtask

    // Reference: borders pass through; interior impulses become the 3x3 median.
    function automatic logic [7:0] modelo(input int k);
        int r, c, n;
        logic [7:0] v [9];
        logic [7:0] t;
        r = k / L;
        c = k % L;
        if (r == 0 || r == H - 1 || c == 0 || c == L - 1) return quadro[k];
        if (quadro[k] != 8'h00 && quadro[k] != 8'hFF) return quadro[k];
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
                v[n] = quadro[(r + dr) * L + (c + dc)];
                n++;
            end
        for (int a = 0; a < 9; a++)
            for (int b = 0; b < 8 - a; b++)
                if (v[b] > v[b + 1]) begin
                    t = v[b]; v[b] = v[b + 1]; v[b + 1] = t;
                end
        return v[4];
    endfunction

    task automatic empilhar();
        saida_t s;
        int r, c;
        corr_esp = 0;
        for (int k = 0; k < N; k++) begin
            s.pix = modelo(k);
            s.fim = (k == N - 1);
            fila.push_back(s);
            r = k / L;
            c = k % L;
            if (r > 0 && r < H - 1 && c > 0 && c < L - 1 &&
                (quadro[k] == 8'h00 || quadro[k] == 8'hFF))
                corr_esp++;
        end
    endtask

    // Downstream ready pattern.
    always @(negedge clk) begin
        case (modo_pronto)
            0:       sai_pronto = 1'b1;
            1:       sai_pronto = ~sai_pronto;
            default: sai_pronto = (int'($urandom_range(0, 99)) < 60);
        endcase
    end

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        saida_t e;
        #2;
        if (!rst) begin
            if (fim_pend) begin
                checar("ocupado_apos_fim", ocupado, 0);
                fim_pend = 0;
            end
            if (sai_valido && t_val < 0) t_val = ciclo;
            if (sai_valido && !sai_pronto) checar("pronto_com_saida_retida", ent_pronto, 0);
            if (sai_valido && sai_pronto && !ignorar) begin
                if (fila.size() == 0) begin
                    checks++;
                    falhas++;
                    $display("FAIL saida_inesperada: got %02h expected none", sai_pixel);
                end else begin
                    e = fila.pop_front();
                    checar("pixel", sai_pixel, e.pix);
                    checar("fim", sai_fim, e.fim);
                    if (sai_fim) begin
                        fins_vistos++;
                        fim_pend = 1;
                        checar("ocupado_no_fim", ocupado, 1);
                    end
                end
            end
        end
    end

    task automatic enviar(input int n, input bit manter, input int gap_pct, input int fins_req);
        int espera;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                ent_valido = 1'b0;
                @(negedge clk);
            end
            ent_valido = 1'b1;
            ent_pixel  = quadro[k];
            #1;
            espera = 0;
            while (!ent_pronto && espera < 100) begin
                @(negedge clk);
                #1;
                espera++;
            end
            if (!ent_pronto) begin
                checks++;
                falhas++;
                $display("FAIL espera_ent_pronto: got timeout expected acceptance of pixel %0d", k);
                ent_valido = 1'b0;
                return;
            end
            if (k == 0 && t_acc < 0) t_acc = ciclo;
            if (k == 0 && fins_req >= 0) checar("fim_antes_do_novo_quadro", fins_vistos, fins_req);
            @(posedge clk);
        end
        if (!manter) begin
            @(negedge clk);
            ent_valido = 1'b0;
        end
    endtask

    task automatic aguardar_fim();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #3;
            if (fila.size() == 0 && !ocupado && !sai_valido) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            falhas++;
            $display("FAIL fim_de_quadro: got timeout expected idle with %0d pending", fila.size());
        end
    endtask

    task automatic checar_contador(input string nome);
`ifdef FILTRO_CONTADOR_EN
        checar(nome, corrigidos, corr_esp);
`else
        checar(nome, ocupado, 0);
`endif
    endtask

    task automatic quadro_rampa();
        for (int k = 0; k < N; k++) quadro[k] = 8'(8'h10 + k);
    endtask

    task automatic quadro_aleatorio();
        int r;
        for (int k = 0; k < N; k++) begin
            r = int'($urandom_range(0, 3));
            if (r == 0)      quadro[k] = 8'h00;
            else if (r == 1) quadro[k] = 8'hFF;
            else             quadro[k] = 8'($urandom_range(1, 254));
        end
    endtask

    initial begin
        rst        = 1'b1;
        ent_valido = 1'b0;
        ent_pixel  = 8'h00;
        #1;
        checar("reset_ent_pronto", ent_pronto, 1);
        checar("reset_sai_valido", sai_valido, 0);
        checar("reset_sai_pixel", sai_pixel, 0);
        checar("reset_sai_fim", sai_fim, 0);
        checar("reset_ocupado", ocupado, 0);
`ifdef FILTRO_CONTADOR_EN
        checar("reset_corrigidos", corrigidos, 0);
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Ramp frame: all passthrough, latency check.
        quadro_rampa();
        empilhar();
        enviar(N, 0, 0, -1);
        aguardar_fim();
        checar("latencia", t_val - t_acc, 6);
        checar_contador("corrigidos_rampa");

        // Interior impulse replaced by median.
        for (int k = 0; k < N; k++) quadro[k] = 8'h40;
        quadro[1 * L + 1] = 8'hFF;
        empilhar();
        enviar(N, 0, 0, -1);
        aguardar_fim();
        checar_contador("corrigidos_impulso");

        // Border impulse passes through.
        for (int k = 0; k < N; k++) quadro[k] = 8'h40;
        quadro[0] = 8'h00;
        empilhar();
        enviar(N, 0, 0, -1);
        aguardar_fim();
        checar_contador("corrigidos_borda");

        // Downstream ready toggling.
        modo_pronto = 1;
        quadro_rampa();
        empilhar();
        enviar(N, 0, 0, -1);
        aguardar_fim();
        modo_pronto = 0;

        // Reset in the middle of a frame.
        quadro_aleatorio();
        ignorar = 1;
        enviar(7, 1, 0, -1);
        @(negedge clk);
        rst        = 1'b1;
        ent_valido = 1'b0;
        #1;
        checar("rst_meio_sai_valido", sai_valido, 0);
        checar("rst_meio_sai_pixel", sai_pixel, 0);
        checar("rst_meio_sai_fim", sai_fim, 0);
        checar("rst_meio_ocupado", ocupado, 0);
        checar("rst_meio_ent_pronto", ent_pronto, 1);
`ifdef FILTRO_CONTADOR_EN
        checar("rst_meio_corrigidos", corrigidos, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fila.delete();
        ignorar = 0;
        repeat (10) @(negedge clk);
        #3;
        checar("sem_saida_pos_reset", sai_valido, 0);
        quadro_rampa();
        quadro[1 * L + 2] = 8'h00;
        empilhar();
        enviar(N, 0, 0, -1);
        aguardar_fim();
        checar_contador("corrigidos_pos_reset");

        // Back-to-back frames with ent_valido held high.
        quadro_aleatorio();
        empilhar();
        enviar(N, 1, 0, -1);
        quadro_aleatorio();
        empilhar();
        enviar(N, 0, 0, fins_vistos + 1);
        aguardar_fim();
        checar_contador("corrigidos_seguidos");

        // Randomized frames, random gaps and backpressure.
        modo_pronto = 2;
        for (int f = 0; f < 12; f++) begin
            quadro_aleatorio();
            empilhar();
            enviar(N, 0, 30, -1);
            aguardar_fim();
            checar_contador("corrigidos_aleatorio");
        end
        modo_pronto = 0;

        checar("fila_vazia", fila.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, falhas);
        $finish;
    end

endmodule
